// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state encoding and default sizes for the Booth
// multiplier operand sequencer, its multiplier and the benches.
`default_nettype none

package booth_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int LAT_DEF   = 18;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    OUT    = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/booth_op_fifo.sv
// booth_op_fifo: operand-pair FIFO, DEPTH entries of 2*WIDTH bits, with
// wrap-bit pointers and combinational head output.
`default_nettype none

module booth_op_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [2*WIDTH-1:0] wr_data,
  input  logic               rd_en,
  output logic [2*WIDTH-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic               do_wr;
  logic               do_rd;

  // Same index with differing wrap bits means every slot is occupied.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/booth_op_sequencer.sv
// booth_op_sequencer: queues operand pairs, feeds them serially to a Booth
// multiplier (start, A, B), waits LAT cycles and holds the product for handoff.
`default_nettype none

module booth_op_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               op_ready,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_data,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               res_valid,
  output logic [2*WIDTH-1:0] res_data,
  input  logic               res_ready,
  output logic               busy
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   cnt;
  logic               rdy_en;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH-1:0] head;

  // rdy_en keeps op_ready low through reset and raises it one edge later.
  assign op_ready = rdy_en && !fifo_full;
  assign busy     = (state != IDLE);

  booth_op_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (op_valid && op_ready),
    .wr_data ({op_a, op_b}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    mul_start  = 1'b0;
    mul_data   = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        mul_start  = 1'b1;
        next_state = LOAD_A;
      end
      LOAD_A: begin
        mul_data   = a_q;
        next_state = LOAD_B;
      end
      LOAD_B: begin
        mul_data   = b_q;
        next_state = WAIT;
      end
      WAIT: begin
        if (cnt == '0) next_state = OUT;
      end
      OUT: begin
        // Going straight to START keeps back-to-back pairs gap-free.
        if (res_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= next_state;
      rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (pop) begin
        a_q <= head[2*WIDTH-1:WIDTH];
        b_q <= head[WIDTH-1:0];
      end
      if (state == LOAD_B) begin
        cnt <= CNT_W'(LAT - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == WAIT && cnt == '0) begin
        res_valid <= 1'b1;
        res_data  <= mul_result;
      end else if (state == OUT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_op_sequencer.sv
// tb_booth_op_sequencer: directed bench for booth_op_sequencer with a
// behavioural multiplier stand-in driven by mul_start/mul_data.
`default_nettype none

module tb_booth_op_sequencer;

  localparam int WIDTH = 16;
  localparam int LAT   = 18;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                op_valid;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic                op_ready;
  logic                mul_start;
  logic [WIDTH-1:0]    mul_data;
  logic [2*WIDTH-1:0]  mul_result;
  logic                res_valid;
  logic [2*WIDTH-1:0]  res_data;
  logic                res_ready;
  logic                busy;

  int checks = 0;
  int errors = 0;

  booth_op_sequencer #(
    .WIDTH (WIDTH),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_ready   (op_ready),
    .mul_start  (mul_start),
    .mul_data   (mul_data),
    .mul_result (mul_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: start, then A beat, then B beat; product is garbage
  // until the B beat has been seen.
  logic [1:0]       ph;
  logic [WIDTH-1:0] ma;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph         <= 2'd0;
      ma         <= '0;
      mul_result <= 32'hDEAD_BEEF;
    end else if (mul_start) begin
      ph         <= 2'd1;
      mul_result <= 32'hDEAD_BEEF;
    end else if (ph == 2'd1) begin
      ma <= mul_data;
      ph <= 2'd2;
    end else if (ph == 2'd2) begin
      mul_result <= $signed(ma) * $signed(mul_data);
      ph         <= 2'd0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    check("res_valid_timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid = 1'b0;
  endtask

  logic [WIDTH-1:0]   pa  [5];
  logic [WIDTH-1:0]   pb  [5];
  logic [2*WIDTH-1:0] exp_p [5];
  int n;
  int stray;

  initial begin
    pa[0] = 16'd1;    pb[0] = 16'd1;    exp_p[0] = 32'h0000_0001;
    pa[1] = 16'hFFFF; pb[1] = 16'd5;    exp_p[1] = 32'hFFFF_FFFB;
    pa[2] = 16'd100;  pb[2] = 16'hFFFE; exp_p[2] = 32'hFFFF_FF38;
    pa[3] = 16'd300;  pb[3] = 16'd400;  exp_p[3] = 32'h0001_D4C0;
    pa[4] = 16'h8000; pb[4] = 16'h8000; exp_p[4] = 32'h4000_0000;

    rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (3) tick();
    check("rst_op_ready",  64'(op_ready),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data",  64'(res_data),  64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_mul_data",  64'(mul_data),  64'd0);
    rst_n = 1'b1;
    #1;
    check("op_ready_before_edge", 64'(op_ready), 64'd0);
    tick();
    check("op_ready_first_edge", 64'(op_ready), 64'd1);

    // Single pair 10 x 13, beat-by-beat
    push(16'd10, 16'd13);
    check("idle_before_pop", 64'(busy), 64'd0);
    tick();
    check("start_strobe", 64'(mul_start), 64'd1);
    check("start_data",   64'(mul_data),  64'd0);
    check("start_busy",   64'(busy),      64'd1);
    tick();
    check("load_a_start", 64'(mul_start), 64'd0);
    check("load_a_data",  64'(mul_data),  64'd10);
    tick();
    check("load_b_data",  64'(mul_data),  64'd13);
    tick();
    check("wait_data",    64'(mul_data),  64'd0);
    wait_valid(n);
    check("pop_to_valid_latency", 64'(n + 3), 64'd21);
    check("prod_10x13", 64'(res_data), 64'd130);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("accept_clears_valid", 64'(res_valid), 64'd0);
    check("accept_to_idle",      64'(busy),      64'd0);

    // -3 x 7, held while res_ready is low
    push(16'hFFFD, 16'd7);
    wait_valid(n);
    check("prod_m3x7", 64'(res_data), 64'hFFFF_FFEB);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_data",  64'(res_data),  64'hFFFF_FFEB);
    end

    // Fill the FIFO while OUT stalls, then pop with a write pending at full
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 64'(op_ready), 64'd1);
      push(pa[i], pb[i]);
    end
    check("full_ready_low", 64'(op_ready), 64'd0);
    op_valid = 1'b1; op_a = pa[4]; op_b = pb[4];
    res_ready = 1'b1;
    tick();
    check("refused_write_ready", 64'(op_ready), 64'd1);
    check("pop_from_out_busy",   64'(busy),     64'd1);
    tick();
    op_valid = 1'b0;
    check("refill_full", 64'(op_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      wait_valid(n);
      if (k > 0) check("back_to_back_gap", 64'(n), 64'd21);
      check("burst_product", 64'(res_data), 64'(exp_p[k]));
      tick();
    end
    check("burst_done_idle", 64'(busy), 64'd0);
    res_ready = 1'b0;

    // Reset during WAIT with two pairs queued
    push(16'd3, 16'd4);
    push(16'd5, 16'd6);
    push(16'd7, 16'd8);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("wait_rst_busy",      64'(busy),      64'd0);
    check("wait_rst_op_ready",  64'(op_ready),  64'd0);
    check("wait_rst_mul_start", 64'(mul_start), 64'd0);
    check("wait_rst_mul_data",  64'(mul_data),  64'd0);
    check("wait_rst_res_valid", 64'(res_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (res_valid || busy) stray++;
    end
    check("no_stray_products", 64'(stray), 64'd0);
    res_ready = 1'b0;

    // Reset while a product is held in OUT
    push(16'd2, 16'd9);
    wait_valid(n);
    check("out_prod_2x9", 64'(res_data), 64'd18);
    #2;
    rst_n = 1'b0;
    #1;
    check("out_rst_res_valid", 64'(res_valid), 64'd0);
    check("out_rst_res_data",  64'(res_data),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/booth_op_sequencer.md
BOOTH_OP_SEQUENCER -- requirements
Module: booth_op_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: operand width; the product is 2*WIDTH.
REQ-002 Parameter LAT, default 18: cycles from the multiplier-operand beat to a valid multiplier result.
REQ-003 Parameter DEPTH, default 4: operand FIFO entries, power of two.
REQ-004 clk  input  1: single clock; all state is updated on the rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 op_valid  input  1: an operand pair is offered.
REQ-007 op_a  input  WIDTH: multiplicand, two's complement.
REQ-008 op_b  input  WIDTH: multiplier, two's complement.
REQ-009 op_ready  output  1: the FIFO can accept a pair.
REQ-010 mul_start  output  1: start strobe to the Booth multiplier.
REQ-011 mul_data  output  WIDTH: serial operand bus to the multiplier's data_in.
REQ-012 mul_result  input  2*WIDTH: multiplier product.
REQ-013 res_valid  output  1: res_data holds a captured product.
REQ-014 res_data  output  2*WIDTH: captured product.
REQ-015 res_ready  input  1: the downstream stage accepts the product.
REQ-016 busy  output  1: the FSM is not in IDLE.

Function
REQ-017 A pair SHALL be written to the FIFO on any cycle where op_valid and op_ready are both high; op_ready SHALL equal not-full.
REQ-018 FIFO pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty SHALL be decoded from the MSB and the index bits.
REQ-019 When a write and a read occur in the same cycle with the FIFO full, the read SHALL proceed and the write SHALL be refused, because op_ready is low.
REQ-020 The FSM SHALL have the states IDLE, START, LOAD_A, LOAD_B, WAIT and OUT.
REQ-021 IDLE SHALL go to START when the FIFO is not empty, popping the head pair into the registers a_q and b_q.
REQ-022 In START, mul_start SHALL be 1 for exactly one cycle, with mul_data=0.
REQ-023 In LOAD_A, mul_data SHALL be a_q for one cycle; in LOAD_B, mul_data SHALL be b_q for one cycle.
REQ-024 mul_start SHALL be 0 and mul_data SHALL be 0 in every state other than those in REQ-022 and REQ-023.
REQ-025 WAIT SHALL count LAT cycles with a down-counter loaded with LAT-1 on leaving LOAD_B.
REQ-026 At count 0, WAIT SHALL capture mul_result into res_data, set res_valid and go to OUT.
REQ-027 The latency from pop to res_valid SHALL be 3+LAT cycles.
REQ-028 In OUT, res_valid and res_data SHALL hold stable until res_ready is high.
REQ-029 On acceptance in OUT, the FSM SHALL go to START directly if the FIFO is not empty, otherwise to IDLE; there is no idle cycle between back-to-back pairs.
REQ-030 res_ready SHALL be ignored outside OUT.
REQ-031 FIFO writes SHALL continue in all FSM states.
REQ-032 The block SHALL perform no arithmetic on operands or results; it only transports them, so sign is preserved end to end.

Reset
REQ-033 While rst_n=0, the FSM SHALL be IDLE and the FIFO pointers SHALL be 0.
REQ-034 While rst_n=0, op_ready=0 and every other output SHALL be 0.
REQ-035 op_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-036 Reset asserted mid-operation SHALL drop the in-flight pair and all queued pairs.
REQ-037 Reset asserted mid-operation SHALL clear res_valid immediately, asynchronously.
REQ-038 The FIFO storage array SHALL have no reset.

Structure
REQ-039 A shared package booth_pkg SHALL hold the state enum, the WIDTH default and the LAT default, for reuse by the multiplier and the benches.
REQ-040 The FIFO SHALL be a sub-module, booth_op_fifo, with parameters WIDTH and DEPTH and a 2*WIDTH data path; the FSM, counter and result register stay in the top module.

Verification
REQ-041 Single pair a=10, b=13 with a multiplier model -> mul_start for 1 cycle, mul_data 10 then 13, res_data=130 exactly 21 cycles after the pop.
REQ-042 a=-3, b=7 -> res_data=32'hFFFFFFEB, with res_valid held for 5 cycles while res_ready=0.
REQ-043 Push 5 pairs back-to-back with res_ready=1 -> op_ready=0 after 4 pairs once the first pop has been delayed; all 5 products come out in order with no gap cycle.
REQ-044 rst_n pulsed low during WAIT with 2 pairs queued -> all outputs 0 at once; after release, busy=0 and there are no stray products.
REQ-045 Simultaneous push and pop with the FIFO full -> the write is refused, the pointer wraps correctly, and the next 4 products match the pushed order.
